// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD time-of-day counter with validated digit load and hold.
// Optional alarm compare enabled by defining TIME_KEEPER_ALARM_EN.
module time_keeper #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hold,
   input  logic       load_valid,
   input  logic [1:0] i_hours_left,
   input  logic [3:0] i_hours_right,
   input  logic [2:0] i_minutes_left,
   input  logic [3:0] i_minutes_right,
   output logic       load_ack,
   output logic       load_err,
   output logic [1:0] o_hours_left,
   output logic [3:0] o_hours_right,
   output logic [2:0] o_minutes_left,
   output logic [3:0] o_minutes_right,
   output logic [5:0] o_seconds,
   output logic       sec_tick,
   output logic       day_pulse
`ifdef TIME_KEEPER_ALARM_EN
   ,
   input  logic       alarm_load,
   input  logic [1:0] i_alarm_hl,
   input  logic [3:0] i_alarm_hr,
   input  logic [2:0] i_alarm_ml,
   input  logic [3:0] i_alarm_mr,
   output logic       alarm_hit
`endif
);
   function automatic logic legal_f(input logic [1:0] hl, input logic [3:0] hr,
                                    input logic [2:0] ml, input logic [3:0] mr);
      return hl <= 2'd2 && hr <= 4'd9 && !(hl == 2'd2 && hr > 4'd3) && ml <= 3'd5 && mr <= 4'd9;
   endfunction

   logic [PRESC_W-1:0] presc;
   logic tc, ld_ok, tick, sec_wrap, c_ml, c_h, day;
   logic [5:0] n_sec;
   logic [3:0] n_mr, n_hr;
   logic [2:0] n_ml;
   logic [1:0] n_hl;

   assign tc    = !hold && presc == PRESC_W'(TICKS_PER_SEC - 1);
   assign ld_ok = load_valid && legal_f(i_hours_left, i_hours_right, i_minutes_left, i_minutes_right);
   // a load in the terminal-count cycle swallows that second
   assign tick  = tc && !ld_ok;

   always_comb begin
      sec_wrap = o_seconds == 6'd59;
      c_ml     = sec_wrap && o_minutes_right == 4'd9;
      c_h      = c_ml && o_minutes_left == 3'd5;
      day      = c_h && o_hours_left == 2'd2 && o_hours_right == 4'd3;
      n_sec    = sec_wrap ? 6'd0 : o_seconds + 6'd1;
      n_mr     = !sec_wrap ? o_minutes_right : c_ml ? 4'd0 : o_minutes_right + 4'd1;
      n_ml     = !c_ml ? o_minutes_left : c_h ? 3'd0 : o_minutes_left + 3'd1;
      n_hr     = !c_h ? o_hours_right : (day || o_hours_right == 4'd9) ? 4'd0 : o_hours_right + 4'd1;
      n_hl     = !c_h ? o_hours_left : day ? 2'd0 : o_hours_right == 4'd9 ? o_hours_left + 2'd1 : o_hours_left;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc           <= '0;
         load_ack        <= 1'b0;
         load_err        <= 1'b0;
         sec_tick        <= 1'b0;
         day_pulse       <= 1'b0;
         o_hours_left    <= '0;
         o_hours_right   <= '0;
         o_minutes_left  <= '0;
         o_minutes_right <= '0;
         o_seconds       <= '0;
      end else begin
         presc     <= (hold || tc || ld_ok) ? '0 : presc + PRESC_W'(1);
         load_ack  <= ld_ok;
         load_err  <= load_valid && !ld_ok;
         sec_tick  <= tick;
         day_pulse <= tick && day;
         if (ld_ok) begin
            o_hours_left    <= i_hours_left;
            o_hours_right   <= i_hours_right;
            o_minutes_left  <= i_minutes_left;
            o_minutes_right <= i_minutes_right;
            o_seconds       <= '0;
         end else if (tick) begin
            o_hours_left    <= n_hl;
            o_hours_right   <= n_hr;
            o_minutes_left  <= n_ml;
            o_minutes_right <= n_mr;
            o_seconds       <= n_sec;
         end
      end
   end

`ifdef TIME_KEEPER_ALARM_EN
   logic [1:0] a_hl;
   logic [3:0] a_hr, a_mr;
   logic [2:0] a_ml;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_hl      <= '0;
         a_hr      <= '0;
         a_ml      <= '0;
         a_mr      <= '0;
         alarm_hit <= 1'b0;
      end else begin
         if (alarm_load && legal_f(i_alarm_hl, i_alarm_hr, i_alarm_ml, i_alarm_mr)) begin
            a_hl <= i_alarm_hl;
            a_hr <= i_alarm_hr;
            a_ml <= i_alarm_ml;
            a_mr <= i_alarm_mr;
         end
         alarm_hit <= tick && sec_wrap && {n_hl, n_hr, n_ml, n_mr} == {a_hl, a_hr, a_ml, a_mr};
      end
   end
`else
`endif
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed self-checking bench for time_keeper at TICKS_PER_SEC=4.
module tb_time_keeper;
   logic clk = 1'b0, rst = 1'b1, hold = 1'b0, load_valid = 1'b0;
   logic [1:0] i_hl = '0, o_hl;
   logic [3:0] i_hr = '0, o_hr, i_mr = '0, o_mr;
   logic [2:0] i_ml = '0, o_ml;
   logic [5:0] o_sec;
   logic load_ack, load_err, sec_tick, day_pulse;
   logic [15:0] hm;
   int checks = 0, failures = 0, cnt;
`ifdef TIME_KEEPER_ALARM_EN
   logic alarm_load = 1'b0, alarm_hit;
   logic [1:0] a_hl = '0;
   logic [3:0] a_hr = '0, a_mr = '0;
   logic [2:0] a_ml = '0;
`endif

   time_keeper #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut (
      .clk(clk), .rst(rst), .hold(hold), .load_valid(load_valid),
      .i_hours_left(i_hl), .i_hours_right(i_hr), .i_minutes_left(i_ml), .i_minutes_right(i_mr),
      .load_ack(load_ack), .load_err(load_err),
      .o_hours_left(o_hl), .o_hours_right(o_hr), .o_minutes_left(o_ml), .o_minutes_right(o_mr),
      .o_seconds(o_sec), .sec_tick(sec_tick), .day_pulse(day_pulse)
`ifdef TIME_KEEPER_ALARM_EN
      , .alarm_load(alarm_load), .i_alarm_hl(a_hl), .i_alarm_hr(a_hr), .i_alarm_ml(a_ml),
      .i_alarm_mr(a_mr), .alarm_hit(alarm_hit)
`endif
   );

   always #5 clk = ~clk;
   assign hm = {2'b00, o_hl, o_hr, 1'b0, o_ml, o_mr};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] hl, input logic [3:0] hr, input logic [2:0] ml, input logic [3:0] mr);
      {i_hl, i_hr, i_ml, i_mr} = {hl, hr, ml, mr};
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("rst_hm", hm, 16'h0000);
      chk("rst_sec", o_sec, 0);
      chk("rst_flags", {load_ack, load_err, sec_tick, day_pulse}, 4'b0000);
      rst = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk($sformatf("tick_%0d", i), sec_tick, (i % 4 == 0));
      end
      chk("sec_after12", o_sec, 3);

      load(2'd2, 4'd3, 3'd5, 4'd9);
      chk("ld2359_ack", load_ack, 1);
      chk("ld2359_hm", hm, 16'h2359);
      chk("ld2359_sec", o_sec, 0);
      step();
      chk("ld2359_ack_once", load_ack, 0);
      cnt = 0;
      repeat (235) begin
         step();
         cnt += day_pulse;
      end
      chk("pre_roll_hm", hm, 16'h2359);
      chk("pre_roll_sec", o_sec, 59);
      repeat (3) begin
         step();
         cnt += day_pulse;
      end
      chk("no_early_day", cnt, 0);
      step();
      chk("roll_hm", hm, 16'h0000);
      chk("roll_sec", o_sec, 0);
      chk("roll_day", day_pulse, 1);
      chk("roll_tick", sec_tick, 1);
      step();
      chk("day_once", day_pulse, 0);

      load(2'd2, 4'd4, 3'd0, 4'd0);
      chk("bad24_err", load_err, 1);
      chk("bad24_ack", load_ack, 0);
      chk("bad24_hm", hm, 16'h0000);
      step();
      chk("err_once", load_err, 0);
      load(2'd1, 4'd9, 3'd6, 4'd0);
      chk("bad60_err", load_err, 1);
      chk("bad60_ack", load_ack, 0);
      chk("bad60_hm", hm, 16'h0000);
      load(2'd2, 4'd10, 3'd0, 4'd0);
      chk("bad2a_err", load_err, 1);
      chk("bad2a_ack", load_ack, 0);
      chk("bad2a_hm", hm, 16'h0000);

      load(2'd0, 4'd9, 3'd5, 4'd9);
      repeat (236) step();
      chk("t095959_hm", hm, 16'h0959);
      chk("t095959_sec", o_sec, 59);
      repeat (3) step();
      load(2'd0, 4'd9, 3'd5, 4'd9);
      chk("race_hm", hm, 16'h0959);
      chk("race_sec", o_sec, 0);
      chk("race_tick", sec_tick, 0);
      chk("race_ack", load_ack, 1);
      chk("race_day", day_pulse, 0);

      load(2'd1, 4'd9, 3'd5, 4'd9);
      repeat (240) step();
      chk("t2000_hm", hm, 16'h2000);
      chk("t2000_sec", o_sec, 0);

      load(2'd0, 4'd5, 3'd0, 4'd7);
      repeat (120) step();
      chk("t050730_sec", o_sec, 30);
      hold = 1'b1;
      cnt = 0;
      repeat (20) begin
         step();
         cnt += sec_tick;
      end
      chk("hold_ticks", cnt, 0);
      chk("hold_hm", hm, 16'h0507);
      chk("hold_sec", o_sec, 30);
      hold = 1'b0;
      repeat (3) step();
      chk("unhold_early", {sec_tick, 2'b00, o_sec}, {1'b0, 2'b00, 6'd30});
      step();
      chk("unhold_tick", sec_tick, 1);
      chk("unhold_sec", o_sec, 31);

      repeat (2) step();
      {i_hl, i_hr, i_ml, i_mr} = {2'd1, 4'd2, 3'd3, 4'd4};
      load_valid = 1'b1;
      rst = 1'b1;
      step();
      load_valid = 1'b0;
      rst = 1'b0;
      chk("rstld_ack", load_ack, 0);
      chk("rstld_hm", hm, 16'h0000);
      chk("rstld_sec", o_sec, 0);
      repeat (3) step();
      chk("rst_presc_early", sec_tick, 0);
      step();
      chk("rst_presc_tick", sec_tick, 1);

`ifdef TIME_KEEPER_ALARM_EN
      {a_hl, a_hr, a_ml, a_mr} = {2'd0, 4'd0, 3'd0, 4'd1};
      alarm_load = 1'b1;
      load(2'd0, 4'd0, 3'd0, 4'd0);
      alarm_load = 1'b0;
      cnt = 0;
      repeat (240) begin
         step();
         cnt += alarm_hit;
      end
      chk("alarm_hit", alarm_hit, 1);
      chk("alarm_hm", hm, 16'h0001);
      chk("alarm_count", cnt, 1);
      load(2'd0, 4'd0, 3'd0, 4'd1);
      chk("alarm_load_nohit", alarm_hit, 0);
      step();
      chk("alarm_load_nohit2", alarm_hit, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Running 24-hour time-of-day counter that consumes the BCD digits produced by the time-setting editor. It loads the digits on a valid/ack handshake, then advances HH:MM:SS from a prescaled system clock. Outputs feed the display driver directly.
- Counting pauses while the editor is active.
- Illegal digit combinations are rejected.

Parameters:
- TICKS_PER_SEC, 50_000_000: clk cycles per second (>=2).
- PRESC_W, 26: prescaler counter width; must satisfy 2**PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- hold  in  1  driven from set_time_en; 1 = editing in progress, counting frozen
- load_valid  in  1  request to load i_* digits (single-cycle or level)
- i_hours_left  in  2  tens of hours, 0..2
- i_hours_right  in  4  units of hours, BCD
- i_minutes_left  in  3  tens of minutes, 0..5
- i_minutes_right  in  4  units of minutes, BCD
- load_ack  out  1  one-cycle pulse: load accepted
- load_err  out  1  one-cycle pulse: load rejected, illegal digits
- o_hours_left  out  2  current tens of hours
- o_hours_right  out  4  current units of hours
- o_minutes_left  out  3  current tens of minutes
- o_minutes_right  out  4  current units of minutes
- o_seconds  out  6  current seconds, binary 0..59
- sec_tick  out  1  one-cycle pulse per counted second
- day_pulse  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset (rst=1 at a clk edge): all outputs and internal counters go to 0. Displayed time is 00:00:00.
- All outputs are registered. No combinational input-to-output paths.
- Prescaler: counts 0..TICKS_PER_SEC-1 while hold=0.
  - At the terminal count it wraps to 0, and sec_tick=1 in the following cycle together with the seconds increment.
  - While hold=1 the prescaler is held at 0 and no sec_tick is produced.
  - After hold falls, the first sec_tick occurs TICKS_PER_SEC cycles later.
- Seconds: increment on each tick. 59 -> 0 carries into minutes.
- Minutes: units 0..9; 9 -> 0 carries into tens. Tens 0..5; 5 -> 0 carries into hours.
- Hours:
  - When tens <2, units run 0..9 and 9 -> 0 carries into tens.
  - When tens ==2, units run 0..3, and 23 -> 00 clears tens.
- Day rollover: 23:59:59 + tick -> 00:00:00, with day_pulse=1 in the same cycle the new value appears.
- Load validity check, evaluated on load_valid=1 at edge N. Digits are legal iff all of:
  - i_hours_left <=2
  - i_hours_right <=9
  - i_hours_right <=3 when i_hours_left==2
  - i_minutes_left <=5
  - i_minutes_right <=9
- Legal load: at edge N the time registers take the i_* values, o_seconds=0 and prescaler=0. load_ack=1 during cycle N+1 (visible after edge N), for exactly one cycle.
- Illegal load: time is unchanged, load_err=1 for one cycle after edge N, load_ack stays 0.
- Level-held load_valid: reloads and re-acks every cycle; this is legal.
- Load is accepted regardless of hold.
- Load and prescaler terminal count in the same cycle: the load wins and the tick is discarded, so no sec_tick and no day_pulse.
- rst and load_valid together: rst wins and no ack is produced.
- Reset mid-second: the prescaler restarts from 0.

Optional Feature:
Macro: TIME_KEEPER_ALARM_EN.
- Defined:
  - Adds ports:
    - alarm_load in 1
    - i_alarm_hl in 2, i_alarm_hr in 4, i_alarm_ml in 3, i_alarm_mr in 4
    - alarm_hit out 1
  - alarm_load=1 latches the alarm digits. They are validated with the same rule as a time load; illegal values are ignored. Reset value of the alarm registers is 00:00.
  - alarm_hit is a one-cycle pulse when counting (never a load) produces HH:MM == alarm with seconds==0. It coincides with that second's sec_tick.
- Undefined: no alarm ports or registers, and identical behaviour otherwise.

Test Plan (TICKS_PER_SEC=4):
- Reset, then 12 cycles with hold=0 -> outputs 00:00:00 after reset; sec_tick every 4th cycle; o_seconds=3 after 12 cycles.
- Load 23:59, run 60 s -> 23:59:59 then 00:00:00 with day_pulse=1 for exactly one cycle, coincident with the rollover.
- Load 24:00, then 19:60, then 2A:00 -> load_err pulses each time; load_ack=0; time unchanged.
- Load 09:59 at 09:59:59 aligned with prescaler terminal -> load wins: 09:59:00, no sec_tick that cycle; load_ack one cycle later. Load 19:59, run 60 s -> 20:00:00.
- hold=1 for 20 cycles at 05:07:30 -> no sec_tick and time frozen. After hold=0, first tick after 4 cycles gives 05:07:31.
- (ALARM_EN) alarm 00:01, time loaded 00:00 -> alarm_hit once at 00:01:00. Then load 00:01 -> no alarm_hit.
